// File: rtl/jump_base_rd_ctrl_if.sv
// Bundle of the jump-base read controller's handshake and RF-port signals.
//   slave  : the controller side (jump_base_rd_ctrl)
//   master : the environment side (jump handler, scoreboard, alt requester, RF)
// Signals:
//   has_mispredict        flush, aborts any jump-base sequence
//   jmp_req/jmp_reg       jump base request and register index; jmp_ack accepts it
//   sb_query_reg/sb_busy  scoreboard query of the held register and its busy flag
//   alt_req/alt_reg       alternate read request; alt_gnt grants the port
//   alt_valid/alt_data    registered alternate read result
//   rf_rd_en/rf_rd_addr   RF read strobe and index; rf_rd_data returns a cycle later
//   jump_base_rdy         one-cycle pulse qualifying jump_base
interface jump_base_rd_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
);
  logic              has_mispredict;
  logic              jmp_req;
  logic [REG_W-1:0]  jmp_reg;
  logic              jmp_ack;
  logic [REG_W-1:0]  sb_query_reg;
  logic              sb_busy;
  logic              alt_req;
  logic [REG_W-1:0]  alt_reg;
  logic              alt_gnt;
  logic              alt_valid;
  logic [DATA_W-1:0] alt_data;
  logic              rf_rd_en;
  logic [REG_W-1:0]  rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              jump_base_rdy;
  logic [DATA_W-1:0] jump_base;

  modport slave (
    input  has_mispredict, jmp_req, jmp_reg, sb_busy, alt_req, alt_reg, rf_rd_data,
    output jmp_ack, sb_query_reg, alt_gnt, alt_valid, alt_data, rf_rd_en, rf_rd_addr,
           jump_base_rdy, jump_base
  );

  modport master (
    output has_mispredict, jmp_req, jmp_reg, sb_busy, alt_req, alt_reg, rf_rd_data,
    input  jmp_ack, sb_query_reg, alt_gnt, alt_valid, alt_data, rf_rd_en, rf_rd_addr,
           jump_base_rdy, jump_base
  );
endinterface

// File: rtl/jump_base_rd_ctrl.sv
// Sequences the register-file read of a register-based jump's base value.
// Waits for the scoreboard to clear the base register, then reads it through
// the single fetch-side RF read port, which is shared with an alternate
// requester under starvation-bounded priority (jump wins unless alt has lost
// STARVE_MAX consecutive contested cycles).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    jump_base_rd_ctrl_if.slave (request, scoreboard, alt and RF signals)
module jump_base_rd_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jump_base_rd_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_RESP} state_t;

  state_t            state;
  logic [REG_W-1:0]  held_reg;
  logic [CNT_W-1:0]  starve_cnt;
  logic              alt_pend;   // alt read issued last cycle, data on rf_rd_data now
  logic [DATA_W-1:0] rd_data;

  logic jump_want;
  logic starved;
  logic jump_win;
  logic alt_win;

  assign rd_data = bus.rf_rd_data;

  always_comb begin
    jump_want = 1'b0;
    if (state == S_ISSUE) jump_want = 1'b1;
    if (state == S_WAIT && !bus.sb_busy) jump_want = 1'b1;
    starved  = (starve_cnt == CNT_W'(STARVE_MAX));
    jump_win = jump_want && !(bus.alt_req && starved);
    alt_win  = bus.alt_req && !jump_win;
  end

  assign bus.jmp_ack      = (state == S_IDLE) && bus.jmp_req && !bus.has_mispredict;
  assign bus.sb_query_reg = held_reg;
  assign bus.alt_gnt      = alt_win;
  assign bus.rf_rd_en     = jump_win || alt_win;
  assign bus.rf_rd_addr   = jump_win ? held_reg : (alt_win ? bus.alt_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      held_reg          <= '0;
      starve_cnt        <= '0;
      alt_pend          <= 1'b0;
      bus.alt_valid     <= 1'b0;
      bus.alt_data      <= '0;
      bus.jump_base_rdy <= 1'b0;
      bus.jump_base     <= '0;
    end else begin
      bus.jump_base_rdy <= 1'b0;

      // Alt reads are never cancelled by a flush.
      alt_pend      <= alt_win;
      bus.alt_valid <= alt_pend;
      if (alt_pend) bus.alt_data <= rd_data;

      if (alt_win)
        starve_cnt <= '0;
      else if (bus.alt_req && jump_win && !starved)
        starve_cnt <= starve_cnt + CNT_W'(1);

      // A flush wins over every transition; a jump read issued in the flush
      // cycle is simply never captured because RESP is not entered.
      case (state)
        S_IDLE: begin
          if (bus.jmp_req && !bus.has_mispredict) begin
            held_reg <= bus.jmp_reg;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.has_mispredict)  state <= S_IDLE;
          else if (!bus.sb_busy)   state <= jump_win ? S_RESP : S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.has_mispredict)  state <= S_IDLE;
          else if (jump_win)       state <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
          if (!bus.has_mispredict) begin
            bus.jump_base     <= rd_data;
            bus.jump_base_rdy <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
